// File: rtl/nvdla_shiftleftsu_pipe.sv
// Signed left shift with saturation: IN_WIDTH operand << shift, clamped to the signed OUT_WIDTH range.
// Latency: 2 cycles (S1 register after the shift/saturate logic, S2 output register); 1 beat/cycle.
// Backpressure: in_prdy = ~s1_vld | ~out_pvld | out_prdy (combinational from out_prdy, no skid buffer).
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : core clock, asynchronous active-low reset
//   in_pvld / in_prdy / in_data / in_shift : input beat (signed operand, left shift amount)
//   out_pvld / out_prdy / out_data / out_sat : output beat (saturated result, saturation flag)
//   sat_cnt / sat_cnt_clr : saturation event counter and its synchronous clear
//
// Optional feature macro: NVDLA_SHIFTLEFT_SAT_CNT_EN
//   defined     -> sat_cnt counts output beats with out_sat=1, sticks at all-ones,
//                  and sat_cnt_clr wins over a same-cycle increment.
//   not defined -> sat_cnt is constant 0, sat_cnt_clr is ignored, no counter flops.

module nvdla_shiftleftsu_pipe #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic                   in_pvld,
    output logic                   in_prdy,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    output logic                   out_pvld,
    input  logic                   out_prdy,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic [CNT_WIDTH-1:0]   sat_cnt,
    input  logic                   sat_cnt_clr
);

    // Wide enough that the largest shift of any operand loses no bits.
    localparam int FULLW = IN_WIDTH + (1 << SHIFT_WIDTH) - 1;

    // ------------------------------------------------------------------
    // Stage 1 arithmetic (combinational, ahead of the S1 register)
    // ------------------------------------------------------------------
    logic [FULLW-1:0]     full_ext;
    logic [FULLW-1:0]     full_shf;
    logic [OUT_WIDTH-1:0] st1_res;
    logic                 st1_sat;

    assign full_ext = {{(FULLW-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign full_shf = full_ext << in_shift;

    generate
        if (OUT_WIDTH < FULLW) begin : g_sat
            // The shifted value fits in OUT_WIDTH signed bits exactly when every
            // bit from the output sign position upward is a copy of the sign.
            logic [FULLW-OUT_WIDTH:0] top_bits;
            logic                     top_same;
            logic [OUT_WIDTH-1:0]     clamp_val;

            assign top_bits  = full_shf[FULLW-1:OUT_WIDTH-1];
            assign top_same  = (&top_bits) | ~(|top_bits);
            assign st1_sat   = ~top_same;
            // Clamp direction follows the operand sign; a zero operand never
            // gets here because it shifts to all-zero bits.
            assign clamp_val = in_data[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            assign st1_res   = st1_sat ? clamp_val : full_shf[OUT_WIDTH-1:0];
        end else begin : g_nosat
            // Output is at least as wide as any shifted value: plain sign extension.
            assign st1_sat = 1'b0;
            assign st1_res = OUT_WIDTH'($signed(full_shf));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Two-stage pipeline registers
    // ------------------------------------------------------------------
    logic                 s1_vld_q, s1_vld_d;
    logic [OUT_WIDTH-1:0] s1_res_q, s1_res_d;
    logic                 s1_sat_q, s1_sat_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [OUT_WIDTH-1:0] s2_dat_q, s2_dat_d;
    logic                 s2_sat_q, s2_sat_d;
    logic                 s1_en;
    logic                 s2_en;

    // S2 advances whenever its slot is empty or being drained; S1 advances
    // whenever its slot is empty or S2 is taking its content.
    assign s2_en   = ~s2_vld_q | out_prdy;
    assign s1_en   = ~s1_vld_q | s2_en;
    assign in_prdy = s1_en;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_res_d = s1_res_q;
        s1_sat_d = s1_sat_q;
        s2_vld_d = s2_vld_q;
        s2_dat_d = s2_dat_q;
        s2_sat_d = s2_sat_q;

        if (s1_en) begin
            s1_vld_d = in_pvld;
            // Data fields only move with a real beat so a bubble leaves them untouched.
            if (in_pvld) begin
                s1_res_d = st1_res;
                s1_sat_d = st1_sat;
            end
        end

        if (s2_en) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_dat_d = s1_res_q;
                s2_sat_d = s1_sat_q;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld_q <= 1'b0;
            s1_res_q <= '0;
            s1_sat_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
            s2_sat_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_res_q <= s1_res_d;
            s1_sat_q <= s1_sat_d;
            s2_vld_q <= s2_vld_d;
            s2_dat_q <= s2_dat_d;
            s2_sat_q <= s2_sat_d;
        end
    end

    assign out_pvld = s2_vld_q;
    assign out_data = s2_dat_q;
    assign out_sat  = s2_sat_q;

    // ------------------------------------------------------------------
    // Saturation event counter
    // ------------------------------------------------------------------
`ifdef NVDLA_SHIFTLEFT_SAT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sat_cnt_clr) begin
            cnt_d = '0;
        end else if (s2_vld_q && out_prdy && s2_sat_q && !(&cnt_q)) begin
            // Sticks at all-ones instead of wrapping.
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_cnt = cnt_q;
`else
    logic unused_sat_cnt_clr;

    assign unused_sat_cnt_clr = sat_cnt_clr;
    assign sat_cnt            = '0;
`endif

endmodule
